// File: rtl/bcd_clock_core.sv
// HH:MM:SS BCD timekeeper with 1 Hz tick-enable prescaler, validated load,
// 12/24 h display, run/pause and a minute-resolution alarm pulse.
module bcd_clock_core #(
    parameter int CLK_HZ = 50_000_000,
    parameter int PRE_W  = 26
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic       load,
    input  logic [7:0] set_hh,
    input  logic [7:0] set_mm,
    input  logic [7:0] set_ss,
    input  logic       mode12,
    input  logic       alarm_en,
    input  logic [7:0] alarm_hh,
    input  logic [7:0] alarm_mm,
    output logic [7:0] hh,
    output logic [7:0] mm,
    output logic [7:0] ss,
    output logic       pm,
    output logic       tick,
    output logic       alarm,
    output logic       load_err
);

    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_HZ - 1);

    logic [PRE_W-1:0] pre;
    logic [3:0]       ss0, ss1, mm0, mm1;
    logic [7:0]       hour;
    logic [3:0]       n_ss0, n_ss1, n_mm0, n_mm1;
    logic [7:0]       n_hour;
    logic             load_ok, alarm_ok, alarm_hit;

    function automatic logic bcd_ok(input logic [7:0] v, input logic [3:0] tens_max);
        return (v[7:4] <= tens_max) && (v[3:0] <= 4'd9);
    endfunction

    function automatic logic hour_ok(input logic [7:0] v);
        return bcd_ok(v, 4'd2) && (v <= 8'h23);
    endfunction

    function automatic logic [7:0] hour_inc(input logic [7:0] h);
        if (h == 8'h23)
            return 8'h00;
        else if (h[3:0] == 4'd9)
            return {h[7:4] + 4'd1, 4'd0};
        else
            return {h[7:4], h[3:0] + 4'd1};
    endfunction

    // 00 shows as 12, 13..23 fold down by twelve; result re-encoded as BCD.
    function automatic logic [7:0] to_12h(input logic [7:0] h);
        logic [4:0] b;
        logic [4:0] d;
        b = {1'b0, h[7:4]} * 5'd10 + {1'b0, h[3:0]};
        if (b == 5'd0)
            d = 5'd12;
        else if (b > 5'd12)
            d = b - 5'd12;
        else
            d = b;
        if (d >= 5'd10)
            return {4'd1, 4'(d - 5'd10)};
        else
            return {4'd0, d[3:0]};
    endfunction

    assign load_ok  = hour_ok(set_hh) && bcd_ok(set_mm, 4'd5) && bcd_ok(set_ss, 4'd5);
    assign alarm_ok = hour_ok(alarm_hh) && bcd_ok(alarm_mm, 4'd5);

    always_comb begin
        n_ss0  = ss0;
        n_ss1  = ss1;
        n_mm0  = mm0;
        n_mm1  = mm1;
        n_hour = hour;
        if (ss0 != 4'd9) begin
            n_ss0 = ss0 + 4'd1;
        end else begin
            n_ss0 = 4'd0;
            if (ss1 != 4'd5) begin
                n_ss1 = ss1 + 4'd1;
            end else begin
                n_ss1 = 4'd0;
                if (mm0 != 4'd9) begin
                    n_mm0 = mm0 + 4'd1;
                end else begin
                    n_mm0 = 4'd0;
                    if (mm1 != 4'd5) begin
                        n_mm1 = mm1 + 4'd1;
                    end else begin
                        n_mm1  = 4'd0;
                        n_hour = hour_inc(hour);
                    end
                end
            end
        end
    end

    // Alarm compares against the post-increment time so it coincides with tick.
    assign alarm_hit = alarm_en && alarm_ok &&
                       ({n_hour, n_mm1, n_mm0, n_ss1, n_ss0} == {alarm_hh, alarm_mm, 8'h00});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre      <= '0;
            ss0      <= 4'd0;
            ss1      <= 4'd0;
            mm0      <= 4'd0;
            mm1      <= 4'd0;
            hour     <= 8'h00;
            tick     <= 1'b0;
            alarm    <= 1'b0;
            load_err <= 1'b0;
        end else begin
            tick     <= 1'b0;
            alarm    <= 1'b0;
            load_err <= 1'b0;
            if (load && load_ok) begin
                pre  <= '0;
                hour <= set_hh;
                mm1  <= set_mm[7:4];
                mm0  <= set_mm[3:0];
                ss1  <= set_ss[7:4];
                ss0  <= set_ss[3:0];
            end else begin
                load_err <= load;
                if (run) begin
                    if (pre == PRE_MAX) begin
                        pre   <= '0;
                        ss0   <= n_ss0;
                        ss1   <= n_ss1;
                        mm0   <= n_mm0;
                        mm1   <= n_mm1;
                        hour  <= n_hour;
                        tick  <= 1'b1;
                        alarm <= alarm_hit;
                    end else begin
                        pre <= pre + 1'b1;
                    end
                end
            end
        end
    end

    assign hh = mode12 ? to_12h(hour) : hour;
    assign mm = {mm1, mm0};
    assign ss = {ss1, ss0};
    assign pm = (hour >= 8'h12);

endmodule

// File: tb/tb_bcd_clock_core.sv
// Scenario bench for bcd_clock_core (CLK_HZ=4): integer time model feeds a
// queue of expected tick results that is drained as the DUT ticks.
module tb_bcd_clock_core;

    logic       clk = 1'b0;
    logic       reset, run, load, mode12, alarm_en;
    logic [7:0] set_hh, set_mm, set_ss, alarm_hh, alarm_mm;
    logic [7:0] hh, mm, ss;
    logic       pm, tick, alarm, load_err;

    int passed = 0;
    int total  = 0;

    typedef struct packed {
        logic [7:0] hh;
        logic [7:0] mm;
        logic [7:0] ss;
        logic       pm;
        logic       alarm;
    } exp_t;

    exp_t sbq[$];
    int   mh, mmin, ms;

    bcd_clock_core #(.CLK_HZ(4), .PRE_W(3)) dut (
        .clk(clk), .reset(reset), .run(run), .load(load),
        .set_hh(set_hh), .set_mm(set_mm), .set_ss(set_ss),
        .mode12(mode12), .alarm_en(alarm_en), .alarm_hh(alarm_hh), .alarm_mm(alarm_mm),
        .hh(hh), .mm(mm), .ss(ss), .pm(pm), .tick(tick), .alarm(alarm), .load_err(load_err)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] t, u;
        t = 4'(v / 10);
        u = 4'(v % 10);
        return {t, u};
    endfunction

    function automatic int disp12(input int h);
        if (h == 0) return 12;
        if (h > 12) return h - 12;
        return h;
    endfunction

    function automatic exp_t mk(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                                input logic p, input logic a);
        exp_t r;
        r.hh = h; r.mm = m; r.ss = s; r.pm = p; r.alarm = a;
        return r;
    endfunction

    // Advance the reference time by one second and queue the expected tick result.
    task automatic model_tick();
        logic al;
        ms++;
        if (ms == 60) begin
            ms = 0;
            mmin++;
            if (mmin == 60) begin
                mmin = 0;
                mh = (mh + 1) % 24;
            end
        end
        al = alarm_en && (to_bcd(mh) == alarm_hh) && (to_bcd(mmin) == alarm_mm) && (ms == 0);
        sbq.push_back(mk(to_bcd(mh), to_bcd(mmin), to_bcd(ms), mh >= 12, al));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_tick(input int max, output bit got, output int n);
        got = 0;
        n   = 0;
        while (!got && n < max) begin
            step();
            n++;
            if (tick) got = 1;
        end
    endtask

    task automatic load_time(input int h, input int m, input int s);
        set_hh = to_bcd(h); set_mm = to_bcd(m); set_ss = to_bcd(s);
        load = 1'b1;
        step();
        load = 1'b0;
        mh = h; mmin = m; ms = s;
    endtask

    task automatic test_reset();
        reset = 1'b1; run = 1'b0; load = 1'b0; mode12 = 1'b0; alarm_en = 1'b0;
        set_hh = 8'h00; set_mm = 8'h00; set_ss = 8'h00; alarm_hh = 8'h00; alarm_mm = 8'h00;
        repeat (3) step();
        total++;
        if ({hh, mm, ss, pm, tick, alarm, load_err} !== 27'd0)
            $display("FAIL reset_state: got %h:%h:%h pm=%b t=%b a=%b e=%b, required all zero",
                     hh, mm, ss, pm, tick, alarm, load_err);
        else passed++;
        mode12 = 1'b1;
        #1;
        total++;
        if (hh !== 8'h12 || pm !== 1'b0)
            $display("FAIL reset_mode12: got hh=%h pm=%b, required hh=12 pm=0", hh, pm);
        else passed++;
        mode12 = 1'b0;
        #1;
        mh = 0; mmin = 0; ms = 0;
        reset = 1'b0;
        run   = 1'b1;
    endtask

    task automatic test_count();
        bit   got;
        int   n, bad;
        exp_t e;
        logic [23:0] snap;
        for (int i = 0; i < 60; i++) model_tick();
        for (int i = 0; i < 60; i++) begin
            wait_tick(8, got, n);
            total++;
            if (!got || n != 4)
                $display("FAIL count_period[%0d]: got tick=%0d after %0d cycles, required 4", i, got, n);
            else passed++;
            e = sbq.pop_front();
            total++;
            if ({hh, mm, ss, pm, alarm} !== {e.hh, e.mm, e.ss, e.pm, e.alarm})
                $display("FAIL count_value[%0d]: got %h:%h:%h pm=%b, required %h:%h:%h pm=%b",
                         i, hh, mm, ss, pm, e.hh, e.mm, e.ss, e.pm);
            else passed++;
        end
        total++;
        if (mm !== 8'h01 || ss !== 8'h00)
            $display("FAIL count_minute: got mm=%h ss=%h, required mm=01 ss=00", mm, ss);
        else passed++;
        run  = 1'b0;
        snap = {hh, mm, ss};
        bad  = 0;
        repeat (10) begin
            step();
            if (tick || {hh, mm, ss} !== snap) bad++;
        end
        total++;
        if (bad != 0)
            $display("FAIL pause_freeze: got %0d bad cycles, required 0", bad);
        else passed++;
    endtask

    task automatic test_rollover();
        bit   got;
        int   n;
        exp_t e;
        run = 1'b1;
        load_time(23, 59, 58);
        total++;
        if (hh !== 8'h23 || pm !== 1'b1 || tick !== 1'b0 || load_err !== 1'b0)
            $display("FAIL roll_load: got hh=%h pm=%b t=%b e=%b, required 23 1 0 0", hh, pm, tick, load_err);
        else passed++;
        model_tick();
        model_tick();
        for (int i = 0; i < 2; i++) begin
            wait_tick(8, got, n);
            e = sbq.pop_front();
            total++;
            if (!got || n != 4 || {hh, mm, ss, pm} !== {e.hh, e.mm, e.ss, e.pm})
                $display("FAIL rollover[%0d]: got %h:%h:%h pm=%b n=%0d, required %h:%h:%h pm=%b n=4",
                         i, hh, mm, ss, pm, n, e.hh, e.mm, e.ss, e.pm);
            else passed++;
        end
        repeat (3) step();
        load_time(10, 20, 30);
        total++;
        if (tick !== 1'b0 || {hh, mm, ss} !== 24'h102030)
            $display("FAIL load_vs_tick: got %h:%h:%h tick=%b, required 10:20:30 tick=0", hh, mm, ss, tick);
        else passed++;
        model_tick();
        wait_tick(8, got, n);
        e = sbq.pop_front();
        total++;
        if (!got || n != 4 || {hh, mm, ss} !== {e.hh, e.mm, e.ss})
            $display("FAIL load_prescaler_clear: got %h:%h:%h n=%0d, required %h:%h:%h n=4",
                     hh, mm, ss, n, e.hh, e.mm, e.ss);
        else passed++;
    endtask

    task automatic test_mode12();
        int   hrs[8]  = '{0, 12, 13, 23, 1, 11, 20, 22};
        int   mins[8] = '{30, 0, 5, 0, 59, 45, 7, 10};
        int   secs[8] = '{0, 0, 0, 0, 59, 1, 33, 20};
        exp_t e;
        run = 1'b0;
        mode12 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            sbq.push_back(mk(to_bcd(disp12(hrs[i])), to_bcd(mins[i]), to_bcd(secs[i]), hrs[i] >= 12, 1'b0));
            load_time(hrs[i], mins[i], secs[i]);
            e = sbq.pop_front();
            total++;
            if ({hh, mm, ss, pm} !== {e.hh, e.mm, e.ss, e.pm})
                $display("FAIL mode12[%0d]: got %h:%h:%h pm=%b, required %h:%h:%h pm=%b",
                         i, hh, mm, ss, pm, e.hh, e.mm, e.ss, e.pm);
            else passed++;
            mode12 = 1'b0;
            #1;
            total++;
            if ({hh, mm, ss} !== {to_bcd(hrs[i]), e.mm, e.ss})
                $display("FAIL mode24[%0d]: got %h:%h:%h, required %h:%h:%h",
                         i, hh, mm, ss, to_bcd(hrs[i]), e.mm, e.ss);
            else passed++;
            mode12 = 1'b1;
        end
        mode12 = 1'b0;
    endtask

    task automatic test_invalid();
        logic [23:0] bad_set[5] = '{24'h240000, 24'h1A0000, 24'h006000, 24'h00005A, 24'h090F00};
        logic [23:0] cur;
        run = 1'b0;
        cur = {to_bcd(mh), to_bcd(mmin), to_bcd(ms)};
        for (int i = 0; i < 5; i++) begin
            {set_hh, set_mm, set_ss} = bad_set[i];
            load = 1'b1;
            step();
            load = 1'b0;
            total++;
            if (load_err !== 1'b1 || {hh, mm, ss} !== cur)
                $display("FAIL invalid_load[%0d]: got err=%b time=%h, required err=1 time=%h",
                         i, load_err, {hh, mm, ss}, cur);
            else passed++;
            step();
            total++;
            if (load_err !== 1'b0)
                $display("FAIL invalid_pulse[%0d]: got err=%b, required 0", i, load_err);
            else passed++;
        end
    endtask

    task automatic test_load_hold();
        bit   got;
        int   n, bad;
        exp_t e;
        run = 1'b1;
        set_hh = 8'h05; set_mm = 8'h06; set_ss = 8'h07;
        load = 1'b1;
        bad = 0;
        repeat (8) begin
            step();
            if (tick || {hh, mm, ss} !== 24'h050607) bad++;
        end
        load = 1'b0;
        mh = 5; mmin = 6; ms = 7;
        total++;
        if (bad != 0)
            $display("FAIL load_hold: got %0d bad cycles, required 0", bad);
        else passed++;
        model_tick();
        wait_tick(8, got, n);
        e = sbq.pop_front();
        total++;
        if (!got || n != 4 || {hh, mm, ss} !== {e.hh, e.mm, e.ss})
            $display("FAIL load_hold_release: got %h:%h:%h n=%0d, required %h:%h:%h n=4",
                     hh, mm, ss, n, e.hh, e.mm, e.ss);
        else passed++;
        repeat (3) step();
        set_hh = 8'h24; set_mm = 8'h00; set_ss = 8'h00;
        load = 1'b1;
        model_tick();
        step();
        load = 1'b0;
        e = sbq.pop_front();
        total++;
        if (tick !== 1'b1 || load_err !== 1'b1 || {hh, mm, ss} !== {e.hh, e.mm, e.ss})
            $display("FAIL invalid_with_tick: got t=%b e=%b %h:%h:%h, required t=1 e=1 %h:%h:%h",
                     tick, load_err, hh, mm, ss, e.hh, e.mm, e.ss);
        else passed++;
    endtask

    task automatic test_alarm();
        bit   got;
        int   n;
        exp_t e;
        run = 1'b1;
        alarm_hh = 8'h07; alarm_mm = 8'h00;
        for (int k = 0; k < 3; k++) begin
            alarm_en = (k != 1);
            if (k == 2) load_time(7, 0, 0);
            else        load_time(6, 59, 59);
            total++;
            if (alarm !== 1'b0)
                $display("FAIL alarm_on_load[%0d]: got alarm=%b, required 0", k, alarm);
            else passed++;
            model_tick();
            wait_tick(8, got, n);
            e = sbq.pop_front();
            total++;
            if (!got || {hh, mm, ss, alarm} !== {e.hh, e.mm, e.ss, e.alarm})
                $display("FAIL alarm_tick[%0d]: got %h:%h:%h alarm=%b, required %h:%h:%h alarm=%b",
                         k, hh, mm, ss, alarm, e.hh, e.mm, e.ss, e.alarm);
            else passed++;
            step();
            total++;
            if (alarm !== 1'b0)
                $display("FAIL alarm_width[%0d]: got alarm=%b one cycle later, required 0", k, alarm);
            else passed++;
        end
        alarm_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit   got;
        int   n;
        exp_t e;
        run = 1'b1;
        load_time(12, 34, 56);
        step();
        step();
        reset = 1'b1;
        #1;
        total++;
        if ({hh, mm, ss, pm, tick, alarm, load_err} !== 27'd0)
            $display("FAIL reset_mid: got %h:%h:%h pm=%b t=%b, required all zero", hh, mm, ss, pm, tick);
        else passed++;
        step();
        reset = 1'b0;
        mh = 0; mmin = 0; ms = 0;
        model_tick();
        wait_tick(8, got, n);
        e = sbq.pop_front();
        total++;
        if (!got || n != 4 || {hh, mm, ss} !== {e.hh, e.mm, e.ss})
            $display("FAIL reset_restart: got %h:%h:%h n=%0d, required %h:%h:%h n=4",
                     hh, mm, ss, n, e.hh, e.mm, e.ss);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_count();
        test_rollover();
        test_mode12();
        test_invalid();
        test_load_hold();
        test_alarm();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
